// File: rtl/ddr2_resp_router.sv
// Return-path router for DDR2 reads: an in-order tag FIFO remembers which requester
// owns each issued read so returning beats can be steered back with one-hot strobes.
module ddr2_resp_router #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int AW     = 3,
  parameter int BEATS  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_issue,
  input  logic [1:0]        cmd_id,
  output logic              cmd_ready,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              resp1_valid,
  output logic              resp2_valid,
  output logic              resp3_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_last,
  output logic [AW:0]       outstanding,
  output logic              err_orphan,
  output logic              err_overflow
);

  localparam int          BC_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
  localparam logic [BC_W-1:0] LAST_BC = BC_W'(BEATS - 1);

  logic [1:0]        r_tag [DEPTH];
  logic [AW-1:0]     r_wp;
  logic [AW-1:0]     r_rp;
  logic [AW:0]       r_cnt;
  logic [BC_W-1:0]   r_bc;
  logic [2:0]        r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic              r_err_orphan;
  logic              r_err_overflow;

  logic              w_push;
  logic              w_reject;
  logic              w_beat;
  logic              w_orphan;
  logic              w_pop;
  logic [1:0]        w_head;
  logic [2:0]        w_sel;

  // Fullness and emptiness are judged on the registered count, so a same-cycle
  // pop never makes room for a push and a same-cycle push never feeds a beat.
  assign w_push   = cmd_issue && (cmd_id != 2'd0) && (r_cnt != FULL);
  assign w_reject = cmd_issue && !w_push;
  assign w_beat   = rd_valid && (r_cnt != '0);
  assign w_orphan = rd_valid && (r_cnt == '0);
  assign w_pop    = w_beat && (r_bc == LAST_BC);
  assign w_head   = r_tag[r_rp];

  // Decode the head tag into the one-hot strobe for the beat being accepted.
  always_comb begin
    w_sel = 3'b000;
    if (w_beat) begin
      case (w_head)
        2'd1:    w_sel = 3'b001;
        2'd2:    w_sel = 3'b010;
        2'd3:    w_sel = 3'b100;
        default: w_sel = 3'b000;
      endcase
    end else begin
      w_sel = 3'b000;
    end
  end

  // Tag FIFO storage, pointers, occupancy and beat position within the head command.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) r_tag[i] <= 2'd0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_bc  <= '0;
    end else begin
      if (w_push) begin
        r_tag[r_wp] <= cmd_id;
        r_wp        <= r_wp + AW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_beat) begin
        r_bc <= w_pop ? '0 : r_bc + BC_W'(1);
      end
    end
  end

  // Registered response outputs and sticky error flags.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_valid        <= 3'b000;
      r_data         <= '0;
      r_last         <= 1'b0;
      r_err_orphan   <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      r_valid <= w_sel;
      r_last  <= w_pop;
      if (w_beat) begin
        r_data <= rd_data;
      end
      if (w_orphan) begin
        r_err_orphan <= 1'b1;
      end
      if (w_reject) begin
        r_err_overflow <= 1'b1;
      end
    end
  end

  assign resp1_valid  = r_valid[0];
  assign resp2_valid  = r_valid[1];
  assign resp3_valid  = r_valid[2];
  assign resp_data    = r_data;
  assign resp_last    = r_last;
  assign outstanding  = r_cnt;
  assign cmd_ready    = (r_cnt != FULL);
  assign err_orphan   = r_err_orphan;
  assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_ddr2_resp_router.sv
// Directed bench for ddr2_resp_router: each scenario task drives vectors and checks
// routed strobes, data, last flags, occupancy and sticky errors against hand values.
module tb_ddr2_resp_router;

  localparam int DATA_W = 32;
  localparam int AW     = 3;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              cmd_issue = 1'b0;
  logic [1:0]        cmd_id = 2'd0;
  logic              cmd_ready;
  logic              rd_valid = 1'b0;
  logic [DATA_W-1:0] rd_data = '0;
  logic              resp1_valid, resp2_valid, resp3_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_last;
  logic [AW:0]       outstanding;
  logic              err_orphan, err_overflow;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] last_data = '0;
  int exp_q[$];

  ddr2_resp_router #(.DATA_W(DATA_W), .DEPTH(8), .AW(AW), .BEATS(2)) dut (
    .CLK(CLK), .RST(RST), .cmd_issue(cmd_issue), .cmd_id(cmd_id), .cmd_ready(cmd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .resp1_valid(resp1_valid),
    .resp2_valid(resp2_valid), .resp3_valid(resp3_valid), .resp_data(resp_data),
    .resp_last(resp_last), .outstanding(outstanding), .err_orphan(err_orphan),
    .err_overflow(err_overflow)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [2:0] onehot(input int id);
    logic [2:0] v;
    v = 3'b000;
    if (id >= 1 && id <= 3) v[id-1] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) step();
    checks++;
    if ({resp3_valid, resp2_valid, resp1_valid, resp_last, resp_data, outstanding, cmd_ready,
         err_orphan, err_overflow} !== {3'b000, 1'b0, 32'h0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: valids=%b last=%b data=%h outst=%0d ready=%b eo=%b ev=%b required 000 0 0 0 1 0 0",
               {resp3_valid, resp2_valid, resp1_valid}, resp_last, resp_data, outstanding,
               cmd_ready, err_orphan, err_overflow);
    end
    #2 RST = 1'b1;
    step();
  endtask

  task automatic test_single();
    cmd_issue = 1'b1; cmd_id = 2'd2;
    step();
    cmd_issue = 1'b0;
    checks++;
    if (outstanding !== 4'd1) begin
      errors++; $display("FAIL single_outst1: got %0d required 1", outstanding);
    end
    for (int i = 0; i < 2; i++) begin
      rd_valid = 1'b1; rd_data = 32'hA0 + i;
      step();
      checks++;
      if ({resp3_valid, resp2_valid, resp1_valid} !== 3'b010 || resp_data !== 32'hA0 + i ||
          resp_last !== (i == 1)) begin
        errors++;
        $display("FAIL single_beat%0d: valids=%b data=%h last=%b required 010 %h %b", i,
                 {resp3_valid, resp2_valid, resp1_valid}, resp_data, resp_last, 32'hA0 + i, i == 1);
      end
    end
    last_data = 32'hA1;
    rd_valid = 1'b0;
    checks++;
    if (outstanding !== 4'd0) begin
      errors++; $display("FAIL single_outst0: got %0d required 0", outstanding);
    end
    step();
    checks++;
    if ({resp3_valid, resp2_valid, resp1_valid} !== 3'b000) begin
      errors++; $display("FAIL single_strobe_drop: valids=%b required 000",
                         {resp3_valid, resp2_valid, resp1_valid});
    end
  endtask

  task automatic test_back_to_back();
    int ids[3] = '{1, 3, 2};
    for (int i = 0; i < 3; i++) begin
      cmd_issue = 1'b1; cmd_id = 2'(ids[i]);
      step();
    end
    cmd_issue = 1'b0;
    checks++;
    if (outstanding !== 4'd3) begin
      errors++; $display("FAIL b2b_outst3: got %0d required 3", outstanding);
    end
    for (int i = 0; i < 6; i++) begin
      rd_valid = 1'b1; rd_data = 32'hB0 + i;
      step();
      checks++;
      if ({resp3_valid, resp2_valid, resp1_valid} !== onehot(ids[i/2]) ||
          resp_data !== 32'hB0 + i || resp_last !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL b2b_beat%0d: valids=%b data=%h last=%b required %b %h %b", i,
                 {resp3_valid, resp2_valid, resp1_valid}, resp_data, resp_last,
                 onehot(ids[i/2]), 32'hB0 + i, i % 2 == 1);
      end
    end
    last_data = 32'hB5;
    rd_valid = 1'b0;
    checks++;
    if (outstanding !== 4'd0) begin
      errors++; $display("FAIL b2b_outst0: got %0d required 0", outstanding);
    end
  endtask

  task automatic test_overflow();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      cmd_issue = 1'b1; cmd_id = 2'(i % 3 + 1);
      exp_q.push_back(i % 3 + 1);
      step();
    end
    cmd_issue = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0 || outstanding !== 4'd8 || err_overflow !== 1'b0) begin
      errors++; $display("FAIL full: ready=%b outst=%0d ov=%b required 0 8 0",
                         cmd_ready, outstanding, err_overflow);
    end
    rd_valid = 1'b1; rd_data = 32'hC0;
    step();
    // Last beat of the head command while issuing into the still-full FIFO.
    cmd_issue = 1'b1; cmd_id = 2'd1; rd_data = 32'hC1;
    step();
    cmd_issue = 1'b0; rd_valid = 1'b0;
    void'(exp_q.pop_front());
    checks++;
    if (outstanding !== 4'd7 || err_overflow !== 1'b1 || resp1_valid !== 1'b1 ||
        resp_last !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL full_issue_pop: outst=%0d ov=%b r1=%b last=%b ready=%b required 7 1 1 1 1",
                         outstanding, err_overflow, resp1_valid, resp_last, cmd_ready);
    end
    cmd_issue = 1'b1; cmd_id = 2'd3; exp_q.push_back(3);
    step();
    cmd_id = 2'd1;
    step();
    cmd_issue = 1'b0;
    checks++;
    if (outstanding !== 4'd8 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL ninth_issue: outst=%0d ready=%b required 8 0", outstanding, cmd_ready);
    end
    for (int i = 0; i < 16; i++) begin
      rd_valid = 1'b1; rd_data = 32'hD0 + i;
      step();
      checks++;
      if ({resp3_valid, resp2_valid, resp1_valid} !== onehot(exp_q[i/2]) ||
          resp_data !== 32'hD0 + i || resp_last !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL drain_beat%0d: valids=%b data=%h last=%b required %b %h %b", i,
                 {resp3_valid, resp2_valid, resp1_valid}, resp_data, resp_last,
                 onehot(exp_q[i/2]), 32'hD0 + i, i % 2 == 1);
      end
    end
    rd_valid = 1'b0;
    checks++;
    if (outstanding !== 4'd0 || cmd_ready !== 1'b1 || err_orphan !== 1'b0) begin
      errors++; $display("FAIL drained: outst=%0d ready=%b orphan=%b required 0 1 0",
                         outstanding, cmd_ready, err_orphan);
    end
    cmd_issue = 1'b1; cmd_id = 2'd3;
    step();
    cmd_issue = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd_valid = 1'b1; rd_data = 32'hE0 + i;
      step();
      checks++;
      if ({resp3_valid, resp2_valid, resp1_valid} !== 3'b100 || resp_data !== 32'hE0 + i) begin
        errors++; $display("FAIL wrap_beat%0d: valids=%b data=%h required 100 %h", i,
                           {resp3_valid, resp2_valid, resp1_valid}, resp_data, 32'hE0 + i);
      end
    end
    last_data = 32'hE1;
    rd_valid = 1'b0;
  endtask

  task automatic test_push_pop();
    int ids[4] = '{1, 2, 3, 2};
    for (int i = 0; i < 3; i++) begin
      cmd_issue = 1'b1; cmd_id = 2'(ids[i]);
      step();
    end
    cmd_issue = 1'b0;
    rd_valid = 1'b1; rd_data = 32'hF0;
    step();
    cmd_issue = 1'b1; cmd_id = 2'd2; rd_data = 32'hF1;
    step();
    cmd_issue = 1'b0;
    checks++;
    if (outstanding !== 4'd3 || resp1_valid !== 1'b1 || resp_last !== 1'b1) begin
      errors++; $display("FAIL push_pop: outst=%0d r1=%b last=%b required 3 1 1",
                         outstanding, resp1_valid, resp_last);
    end
    for (int i = 0; i < 6; i++) begin
      rd_data = 32'hF2 + i;
      step();
      checks++;
      if ({resp3_valid, resp2_valid, resp1_valid} !== onehot(ids[1 + i/2]) ||
          resp_data !== 32'hF2 + i) begin
        errors++; $display("FAIL push_pop_drain%0d: valids=%b data=%h required %b %h", i,
                           {resp3_valid, resp2_valid, resp1_valid}, resp_data,
                           onehot(ids[1 + i/2]), 32'hF2 + i);
      end
    end
    last_data = 32'hF7;
    rd_valid = 1'b0;
    step();
  endtask

  task automatic test_orphan();
    rd_valid = 1'b1; rd_data = 32'h55;
    step();
    rd_valid = 1'b0;
    checks++;
    if ({resp3_valid, resp2_valid, resp1_valid} !== 3'b000 || resp_data !== last_data ||
        err_orphan !== 1'b1 || outstanding !== 4'd0) begin
      errors++; $display("FAIL orphan: valids=%b data=%h orphan=%b outst=%0d required 000 %h 1 0",
                         {resp3_valid, resp2_valid, resp1_valid}, resp_data, err_orphan,
                         outstanding, last_data);
    end
    repeat (3) step();
    checks++;
    if (err_orphan !== 1'b1) begin
      errors++; $display("FAIL orphan_sticky: got %b required 1", err_orphan);
    end
  endtask

  task automatic test_reset_mid_burst();
    cmd_issue = 1'b1; cmd_id = 2'd2;
    step();
    cmd_issue = 1'b0;
    rd_valid = 1'b1; rd_data = 32'h77;
    step();
    rd_valid = 1'b0;
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({resp3_valid, resp2_valid, resp1_valid, resp_last, resp_data, outstanding, cmd_ready,
         err_orphan, err_overflow} !== {3'b000, 1'b0, 32'h0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: valids=%b last=%b data=%h outst=%0d ready=%b eo=%b ev=%b required 000 0 0 0 1 0 0",
               {resp3_valid, resp2_valid, resp1_valid}, resp_last, resp_data, outstanding,
               cmd_ready, err_orphan, err_overflow);
    end
    step();
    #2 RST = 1'b1;
    step();
    // Issue into an empty FIFO alongside a beat: the beat cannot see the new tag.
    cmd_issue = 1'b1; cmd_id = 2'd1; rd_valid = 1'b1; rd_data = 32'h99;
    step();
    cmd_issue = 1'b0; rd_valid = 1'b0;
    checks++;
    if ({resp3_valid, resp2_valid, resp1_valid} !== 3'b000 || err_orphan !== 1'b1 ||
        outstanding !== 4'd1 || resp_data !== 32'h0) begin
      errors++; $display("FAIL push_with_orphan: valids=%b orphan=%b outst=%0d data=%h required 000 1 1 0",
                         {resp3_valid, resp2_valid, resp1_valid}, err_orphan, outstanding, resp_data);
    end
    for (int i = 0; i < 2; i++) begin
      rd_valid = 1'b1; rd_data = 32'h10 + i;
      step();
      checks++;
      if ({resp3_valid, resp2_valid, resp1_valid} !== 3'b001 || resp_data !== 32'h10 + i ||
          resp_last !== (i == 1)) begin
        errors++; $display("FAIL post_reset_beat%0d: valids=%b data=%h last=%b required 001 %h %b", i,
                           {resp3_valid, resp2_valid, resp1_valid}, resp_data, resp_last,
                           32'h10 + i, i == 1);
      end
    end
    rd_valid = 1'b0;
    checks++;
    if (err_overflow !== 1'b0) begin
      errors++; $display("FAIL ov_before_id0: got %b required 0", err_overflow);
    end
    cmd_issue = 1'b1; cmd_id = 2'd0;
    step();
    cmd_issue = 1'b0;
    checks++;
    if (err_overflow !== 1'b1 || outstanding !== 4'd0) begin
      errors++; $display("FAIL id0_reject: ov=%b outst=%0d required 1 0", err_overflow, outstanding);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_push_pop();
    test_orphan();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
